// File: rtl/iir_coeff_loader.sv
// Double-buffered IIR coefficient bank: writes land in shadow, commit swaps shadow->active on the next sample_en.
// Define IIR_COEFF_LOADER_FLUSH_EN to hold filter_flush high for FLUSH_CYCLES after each swap.
module iir_coeff_loader #(
  parameter int M            = 2,
  parameter int COEFF_WIDTH  = 16,
  parameter int Q            = 14,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         sample_en,
  input  logic                         wr_valid,
  output logic                         wr_ready,
  input  logic [$clog2(2*M+1)-1:0]     wr_addr,
  input  logic [COEFF_WIDTH-1:0]       wr_data,
  input  logic                         commit,
  output logic                         busy,
  output logic                         swap_done,
  output logic                         err,
  output logic [(M+1)*COEFF_WIDTH-1:0] packed_b_coeffs,
  output logic [M*COEFF_WIDTH-1:0]     packed_a_coeffs,
  output logic                         filter_flush
);

  localparam int N  = 2*M + 1;
  localparam int AW = $clog2(N);
  localparam logic [COEFF_WIDTH-1:0] ONE = COEFF_WIDTH'(2**Q);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
`ifdef IIR_COEFF_LOADER_FLUSH_EN
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam int CNTW = $clog2(FLUSH_CYCLES + 1);
  logic [CNTW-1:0] flush_cnt;
`endif

  if (FLUSH_CYCLES < 1) begin : g_bad_flush_cycles
    $error("FLUSH_CYCLES must be at least 1");
  end

  logic [1:0]             state;
  logic [COEFF_WIDTH-1:0] shadow [N];
  logic [COEFF_WIDTH-1:0] active [N];
  logic                   wr_fire;
  logic                   addr_ok;
  logic                   swap;

  assign wr_ready = (state == ST_IDLE);
  assign busy     = (state != ST_IDLE);
  assign wr_fire  = wr_valid & wr_ready;
  assign addr_ok  = (wr_addr <= AW'(2*M));
  assign swap     = (state == ST_ARMED) & sample_en;

`ifdef IIR_COEFF_LOADER_FLUSH_EN
  assign filter_flush = (state == ST_FLUSH);
`else
  assign filter_flush = 1'b0;
`endif

  // b0..bM sit at indices 0..M, a1..aM at M+1..2M.
  for (genvar i = 0; i <= M; i++) begin : g_pack_b
    assign packed_b_coeffs[i*COEFF_WIDTH +: COEFF_WIDTH] = active[i];
  end
  for (genvar i = 0; i < M; i++) begin : g_pack_a
    assign packed_a_coeffs[i*COEFF_WIDTH +: COEFF_WIDTH] = active[M+1+i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        shadow[i] <= (i == 0) ? ONE : '0;
        active[i] <= (i == 0) ? ONE : '0;
      end
    end else begin
      if (wr_fire && addr_ok) begin
        shadow[wr_addr] <= wr_data;
      end
      if (swap) begin
        for (int i = 0; i < N; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      swap_done <= 1'b0;
      err       <= 1'b0;
`ifdef IIR_COEFF_LOADER_FLUSH_EN
      flush_cnt <= '0;
`endif
    end else begin
      swap_done <= swap;
      err       <= wr_fire & ~addr_ok;
      case (state)
        ST_IDLE: begin
          // A sample_en coinciding with commit is deliberately not a swap edge.
          if (commit) begin
            state <= ST_ARMED;
          end
        end
        ST_ARMED: begin
          if (sample_en) begin
`ifdef IIR_COEFF_LOADER_FLUSH_EN
            state     <= ST_FLUSH;
            flush_cnt <= CNTW'(FLUSH_CYCLES - 1);
`else
            state     <= ST_IDLE;
`endif
          end
        end
`ifdef IIR_COEFF_LOADER_FLUSH_EN
        ST_FLUSH: begin
          if (flush_cnt == '0) begin
            state <= ST_IDLE;
          end else begin
            flush_cnt <= flush_cnt - 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_coeff_loader.sv
// Directed bench for iir_coeff_loader with a bank-level reference model compared every cycle.
module tb_iir_coeff_loader;

  localparam int FC = 4;
`ifdef IIR_COEFF_LOADER_FLUSH_EN
  localparam int FL = FC;
`else
  localparam int FL = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_en;
  logic        wr_valid;
  logic        wr_ready;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        commit;
  logic        busy;
  logic        swap_done;
  logic        err;
  logic [47:0] packed_b_coeffs;
  logic [31:0] packed_a_coeffs;
  logic        filter_flush;

  int n_chk  = 0;
  int n_pass = 0;
  bit run_cmp = 1'b0;

  iir_coeff_loader #(.M(2), .COEFF_WIDTH(16), .Q(14), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .commit(commit), .busy(busy), .swap_done(swap_done),
    .err(err), .packed_b_coeffs(packed_b_coeffs), .packed_a_coeffs(packed_a_coeffs),
    .filter_flush(filter_flush)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: shadow/active banks, a pending-swap flag and a flush cycle budget.
  logic [15:0] m_sh [5];
  logic [15:0] m_act [5];
  bit m_armed, m_sd, m_err, m_idle;
  int m_fl;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int i = 0; i < 5; i++) begin
          m_sh[i]  = (i == 0) ? 16'h4000 : 16'h0;
          m_act[i] = (i == 0) ? 16'h4000 : 16'h0;
        end
        m_armed = 0; m_fl = 0; m_sd = 0; m_err = 0;
      end else begin
        m_idle = !m_armed && (m_fl == 0);
        m_sd = 0;
        m_err = 0;
        if (m_idle) begin
          if (wr_valid) begin
            if (wr_addr <= 3'd4) m_sh[wr_addr] = wr_data;
            else m_err = 1;
          end
          if (commit) m_armed = 1;
        end else if (m_armed) begin
          if (sample_en) begin
            for (int i = 0; i < 5; i++) m_act[i] = m_sh[i];
            m_sd = 1;
            m_armed = 0;
            m_fl = FL;
          end
        end else begin
          m_fl--;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (run_cmp) begin
      chk("model_b", packed_b_coeffs, {m_act[2], m_act[1], m_act[0]});
      chk("model_a", packed_a_coeffs, {m_act[4], m_act[3]});
      chk("model_wr_ready", wr_ready, (!m_armed && m_fl == 0));
      chk("model_busy", busy, (m_armed || m_fl != 0));
      chk("model_swap_done", swap_done, m_sd);
      chk("model_err", err, m_err);
      chk("model_flush", filter_flush, (m_fl != 0));
    end
  end

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic pulse_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic pulse_sample();
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; sample_en = 0; wr_valid = 0; wr_addr = 0; wr_data = 0; commit = 0;
    repeat (2) @(negedge clk);
    chk("rst_b", packed_b_coeffs, 48'h0000_0000_4000);
    chk("rst_a", packed_a_coeffs, 32'h0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_flush", filter_flush, 1'b0);
    rst = 1'b0;
    run_cmp = 1'b1;
    @(negedge clk);

    // Basic load, commit, swap 5 cycles after commit
    wr(3'd0, 16'h4000); wr(3'd2, 16'hC000); wr(3'd4, 16'hDF62);
    pulse_commit();
    chk("armed_busy", busy, 1'b1);
    chk("armed_wr_ready", wr_ready, 1'b0);
    repeat (4) @(negedge clk);
    sample_en = 1'b1;
    chk("pre_swap_b", packed_b_coeffs, 48'h0000_0000_4000);
    chk("pre_swap_a", packed_a_coeffs, 32'h0);
    @(negedge clk);
    sample_en = 1'b0;
    chk("swap_b", packed_b_coeffs, 48'hC000_0000_4000);
    chk("swap_a", packed_a_coeffs, 32'hDF62_0000);
    for (int k = 1; k <= FC + 1; k++) begin
      chk("swap_done_once", swap_done, (k == 1));
`ifdef IIR_COEFF_LOADER_FLUSH_EN
      chk("flush_window", filter_flush, (k <= FC));
      chk("flush_busy", busy, (k <= FC));
`else
      chk("noflush_flush", filter_flush, 1'b0);
      chk("noflush_busy", busy, 1'b0);
`endif
      @(negedge clk);
    end

    // commit with coincident sample_en: arm only
    wr(3'd1, 16'h1234);
    commit = 1'b1; sample_en = 1'b1;
    @(negedge clk);
    commit = 1'b0; sample_en = 1'b0;
    chk("same_cycle_no_swap", swap_done, 1'b0);
    chk("same_cycle_busy", busy, 1'b1);
    chk("same_cycle_b", packed_b_coeffs, 48'hC000_0000_4000);
    repeat (2) @(negedge clk);
    pulse_sample();
    chk("next_sample_swap", swap_done, 1'b1);
    chk("next_sample_b", packed_b_coeffs, 48'hC000_1234_4000);
    repeat (FC + 1) @(negedge clk);

    // Bad addresses, write+commit together, write while armed
    wr(3'd5, 16'hFFFF);
    chk("err_addr5", err, 1'b1);
    @(negedge clk);
    chk("err_one_cycle", err, 1'b0);
    wr(3'd7, 16'h7777);
    chk("err_addr7", err, 1'b1);
    wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 16'h0ABC; commit = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; commit = 1'b0;
    wr(3'd4, 16'h1111);
    chk("armed_write_no_err", err, 1'b0);
    pulse_sample();
    chk("bad_addr_b", packed_b_coeffs, 48'hC000_1234_4000);
    chk("commit_write_a", packed_a_coeffs, 32'hDF62_0ABC);
    repeat (FC + 1) @(negedge clk);

    // Asynchronous reset while busy
    pulse_commit();
`ifdef IIR_COEFF_LOADER_FLUSH_EN
    pulse_sample();
    chk("pre_rst_flush", filter_flush, 1'b1);
`endif
    #2 rst = 1'b1;
    #1;
    chk("async_rst_flush", filter_flush, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_b", packed_b_coeffs, 48'h0000_0000_4000);
    chk("async_rst_a", packed_a_coeffs, 32'h0);
    chk("async_rst_swap_done", swap_done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wr_ready", wr_ready, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    pulse_commit();
    pulse_sample();
    chk("post_rst_swap", swap_done, 1'b1);
    chk("post_rst_shadow_b", packed_b_coeffs, 48'h0000_0000_4000);
    chk("post_rst_shadow_a", packed_a_coeffs, 32'h0);
    repeat (FC + 2) @(negedge clk);

    run_cmp = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/iir_coeff_loader.md
# iir_coeff_loader

Coefficient bank controller for the `iir_df_i` direct-form-I filter. It accepts coefficient writes into a shadow bank and, on commit, swaps the shadow bank into the active bank on the next sample boundary, so the filter never sees a partially updated set. With the flush option compiled in, it then holds the filter's history in reset for a fixed number of cycles. Its packed outputs drive the filter's `packed_b_coeffs` and `packed_a_coeffs` directly.

## Interface
- `M`, 2: filter order; the bank holds b0..bM and a1..aM.
- `COEFF_WIDTH`, 16: coefficient width in bits, two's complement.
- `Q`, 14: fraction bits; sets the reset value of b0 (1.0 = 2**Q).
- `FLUSH_CYCLES`, 4: cycles `filter_flush` is held high after a swap; must be at least 1.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `sample_en`  in  1  one-cycle strobe marking the filter's sample boundary.
- `wr_valid`  in  1  a coefficient write is offered.
- `wr_ready`  out  1  a write is accepted when `wr_valid & wr_ready`.
- `wr_addr`  in  $clog2(2M+1)  0..M selects b0..bM; M+1..2M selects a1..aM.
- `wr_data`  in  COEFF_WIDTH  coefficient value.
- `commit`  in  1  one-cycle request to arm a swap of the shadow bank.
- `busy`  out  1  high while armed or flushing.
- `swap_done`  out  1  one-cycle pulse on the first cycle the new coefficients are active.
- `err`  out  1  one-cycle pulse when a write is dropped because of a bad address.
- `packed_b_coeffs`  out  (M+1)*COEFF_WIDTH  active {bM..b0}, with b0 in the LSBs.
- `packed_a_coeffs`  out  M*COEFF_WIDTH  active {aM..a1}, with a1 in the LSBs.
- `filter_flush`  out  1  active-high hold for the filter's history registers.

## Operation
- Two banks of 2M+1 registers: shadow and active. Both reset to passthrough: b0 = 2**Q, all other coefficients 0.
- FSM states and transitions:
  - IDLE:
    - `wr_ready`=1.
    - An accepted write with `wr_addr` ≤ 2M stores `wr_data` to shadow[`wr_addr`].
    - An accepted write with `wr_addr` > 2M is dropped, and `err` pulses on the next cycle.
    - `commit` moves the FSM to ARMED.
    - If a write and `commit` occur in the same cycle, the write lands and is part of the swapped set.
  - ARMED:
    - `wr_ready`=0.
    - `commit` is ignored.
    - On `sample_en`, the active bank is loaded with the whole shadow bank in one edge.
    - Then the FSM goes to FLUSH if the flush option is compiled in, otherwise to IDLE.
  - FLUSH:
    - `wr_ready`=0 and `filter_flush`=1.
    - A down-counter loaded with FLUSH_CYCLES counts down; the FSM returns to IDLE when it expires.
- `commit` and `sample_en` in the same cycle while in IDLE: the FSM arms only. The swap uses the next `sample_en`, never the current one.
- The active bank changes only on a swap edge; writes never touch it directly.
- The shadow bank persists after a swap, so a partial rewrite followed by a commit is legal.
- `busy` = (state != IDLE).
- Reset at any point, mid-load or mid-flush: all state returns immediately to reset values. Any shadow contents are lost and no `swap_done` is issued.

## Timing
- Reset values: `wr_ready`=1, `busy`=0, `swap_done`=0, `err`=0, `filter_flush`=0; packed outputs are at passthrough.
- Write accepted at cycle t: shadow is updated at t+1; `err` (bad address) is high at t+1 only.
- Commit at cycle t: `busy` and `wr_ready`=0 take effect from t+1.
- `sample_en` in ARMED at cycle t:
  - The new packed outputs are valid from t+1, and `swap_done`=1 at t+1 only.
  - With flush: `filter_flush`=1 from t+1 through t+FLUSH_CYCLES; `busy`=0 and `wr_ready`=1 from t+FLUSH_CYCLES+1.
  - Without flush: `busy`=0 and `wr_ready`=1 from t+1.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `IIR_COEFF_LOADER_FLUSH_EN`.
- Defined: the FLUSH state and its counter are present, with behaviour as above.
- Undefined: the FLUSH state and counter are removed, `filter_flush` is tied to 0, and ARMED goes directly to IDLE on the swap.

## Test plan
Common setup for all scenarios: M=2, COEFF_WIDTH=16, Q=14.
- Reset → `packed_b_coeffs`=48'h0000_0000_4000, `packed_a_coeffs`=32'h0, `wr_ready`=1, `busy`=0.
- Write addr0=16'h4000, addr2=16'hC000, addr4=16'hDF62, then commit. Pulse `sample_en` 5 cycles later.
  - Outputs stay at passthrough until the cycle after `sample_en`.
  - Then `packed_b_coeffs`=48'hC000_0000_4000 and `packed_a_coeffs`=32'hDF62_0000, with `swap_done` pulsing once.
- With FLUSH defined and FLUSH_CYCLES=4: `filter_flush` is high exactly 4 cycles after the swap; `busy` falls on the 5th cycle after `sample_en`.
- `commit` and `sample_en` in the same cycle → no swap. The swap occurs on the next `sample_en` pulse.
- Write addr=5 → dropped, `err` is high for exactly 1 cycle, and the shadow bank is unchanged (verified by commit and swap).
- Assert `rst` during FLUSH → `filter_flush`=0 and outputs return to passthrough in the same cycle, asynchronously. The FSM is in IDLE after `rst` deasserts.
